// File: rtl/mem_bus_arbiter_decoder_pkg.sv
// Shared types and constants for the memory bus arbiter/decoder.
// FSM states, master ids, arbitration modes and the error read value.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    MST_I = 1'b0,
    MST_D = 1'b1
  } mst_t;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  localparam int ERR_DATA  = 0;

endpackage

// File: rtl/mem_bus_arbiter_decoder_if.sv
// Bundle of the two master request ports and the shared slave bus.
// The 'slave' modport is the arbiter's view; 'master' is the surrounding system.
interface mem_bus_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  // Handshake: i_req/d_req are levels held until the matching one-cycle done
  // pulse, with addr/we/be/wdata stable meanwhile; a new req may follow in the
  // cycle after done. s_ready is honoured only from the selected slave while
  // s_sel is non-zero, and every s_* output is stable for that whole window.
  logic                       i_req;
  logic [ADDR_W-1:0]          i_addr;
  logic                       i_done;
  logic [DATA_W-1:0]          i_rdata;
  logic                       i_err;
  logic                       d_req;
  logic                       d_we;
  logic [DATA_W/8-1:0]        d_be;
  logic [ADDR_W-1:0]          d_addr;
  logic [DATA_W-1:0]          d_wdata;
  logic                       d_done;
  logic [DATA_W-1:0]          d_rdata;
  logic                       d_err;
  logic [NUM_SLAVES-1:0]      s_sel;
  logic                       s_we;
  logic [DATA_W/8-1:0]        s_be;
  logic [ADDR_W-1:0]          s_addr;
  logic [DATA_W-1:0]          s_wdata;
  logic [NUM_SLAVES*DATA_W-1:0] s_rdata;
  logic [NUM_SLAVES-1:0]      s_ready;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, s_rdata, s_ready,
    output i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           s_sel, s_we, s_be, s_addr, s_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, s_rdata, s_ready,
    input  i_done, i_rdata, i_err, d_done, d_rdata, d_err,
           s_sel, s_we, s_be, s_addr, s_wdata
  );
endinterface

// File: rtl/mem_bus_addr_decode.sv
// Combinational region decoder: lowest matching region wins.
// Produces hit flag, one-hot select, region index and word offset in region.
module mem_bus_addr_decode #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 2,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LAST = '0
) (
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  o_hit,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic [IDX_W-1:0]      o_idx,
  output logic [ADDR_W-1:0]     o_offset
);

  always_comb begin
    o_hit    = 1'b0;
    o_sel    = '0;
    o_idx    = '0;
    o_offset = '0;
    // Scan from the top so the lowest matching index is the one left standing.
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if (i_addr >= SLV_BASE[k*ADDR_W +: ADDR_W] &&
          i_addr <= SLV_LAST[k*ADDR_W +: ADDR_W]) begin
        o_hit    = 1'b1;
        o_sel    = NUM_SLAVES'(1) << k;
        o_idx    = IDX_W'(k);
        o_offset = (i_addr - SLV_BASE[k*ADDR_W +: ADDR_W]) >> 2;
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter_decoder.sv
// Registered two-master arbiter and region decoder for the shared slave bus,
// with slave wait states, access timeout and error response for misses.
module mem_bus_arbiter_decoder
  import mem_bus_pkg::*;
#(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE =
    {32'h1001_0108, 32'h1001_0100, 32'h0040_0000, 32'h1001_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_LAST =
    {32'h1001_011F, 32'h1001_0107, 32'h0FFF_FFFF, 32'h1001_00FF},
  parameter int TIMEOUT  = 15,
  parameter int ARB_MODE = ARB_FIXED
) (
  input  logic   clk,
  input  logic   rst_n,
  mem_bus_if.slave bus,
  output state_t o_dbg_state
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                r_state;
  mst_t                  r_mst;
  mst_t                  r_last;
  logic                  r_we;
  logic [BE_W-1:0]       r_be;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W-1:0]     r_rdata;
  logic                  r_err;
  logic [NUM_SLAVES-1:0] r_sel;
  logic [IDX_W-1:0]      r_idx;
  logic [ADDR_W-1:0]     r_offset;
  logic [CNT_W-1:0]      r_cnt;

  mst_t                  w_gnt;
  logic                  w_req_any;
  logic [ADDR_W-1:0]     w_addr;
  logic                  w_hit;
  logic [NUM_SLAVES-1:0] w_sel;
  logic [IDX_W-1:0]      w_idx;
  logic [ADDR_W-1:0]     w_offset;
  logic [DATA_W-1:0]     w_slv_rdata;
  logic                  w_access;
  logic                  w_i_done;
  logic                  w_d_done;

  // In round-robin mode D only wins a tie if I was the last one served.
  always_comb begin
    w_req_any = bus.i_req | bus.d_req;
    if (bus.d_req && (!bus.i_req || ARB_MODE == ARB_FIXED || r_last == MST_I))
      w_gnt = MST_D;
    else
      w_gnt = MST_I;
    w_addr = (w_gnt == MST_D) ? bus.d_addr : bus.i_addr;
  end

  mem_bus_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .SLV_BASE   (SLV_BASE),
    .SLV_LAST   (SLV_LAST)
  ) u_decode (
    .i_addr   (w_addr),
    .o_hit    (w_hit),
    .o_sel    (w_sel),
    .o_idx    (w_idx),
    .o_offset (w_offset)
  );

  assign w_slv_rdata = bus.s_rdata[int'(r_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_mst    <= MST_I;
      r_last   <= MST_I;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
      r_sel    <= '0;
      r_idx    <= '0;
      r_offset <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_any) begin
            r_mst    <= w_gnt;
            r_last   <= w_gnt;
            r_we     <= (w_gnt == MST_D) ? bus.d_we : 1'b0;
            r_be     <= (w_gnt == MST_D) ? bus.d_be : '1;
            r_wdata  <= (w_gnt == MST_D) ? bus.d_wdata : '0;
            r_sel    <= w_sel;
            r_idx    <= w_idx;
            r_offset <= w_offset;
            r_cnt    <= '0;
            if (w_hit) begin
              r_state <= ST_ACCESS;
            end else begin
              r_state <= ST_RESP;
              r_err   <= 1'b1;
              r_rdata <= DATA_W'(ERR_DATA);
            end
          end
        end
        ST_ACCESS: begin
          // A ready on the final counted cycle still completes cleanly.
          if (bus.s_ready[r_idx]) begin
            r_state <= ST_RESP;
            r_err   <= 1'b0;
            r_rdata <= r_we ? DATA_W'(ERR_DATA) : w_slv_rdata;
          end else if (r_cnt == CNT_W'(TIMEOUT)) begin
            r_state <= ST_RESP;
            r_err   <= 1'b1;
            r_rdata <= DATA_W'(ERR_DATA);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_access = (r_state == ST_ACCESS);
  assign w_i_done = (r_state == ST_RESP) && (r_mst == MST_I);
  assign w_d_done = (r_state == ST_RESP) && (r_mst == MST_D);

  assign bus.s_sel   = w_access ? r_sel    : '0;
  assign bus.s_we    = w_access & r_we;
  assign bus.s_be    = w_access ? r_be     : '0;
  assign bus.s_addr  = w_access ? r_offset : '0;
  assign bus.s_wdata = w_access ? r_wdata  : '0;

  assign bus.i_done  = w_i_done;
  assign bus.i_rdata = w_i_done ? r_rdata : '0;
  assign bus.i_err   = w_i_done & r_err;
  assign bus.d_done  = w_d_done;
  assign bus.d_rdata = w_d_done ? r_rdata : '0;
  assign bus.d_err   = w_d_done & r_err;

  assign o_dbg_state = r_state;

endmodule
